// File: rtl/fifo_apb_arbiter_if.sv
// Requester handshakes plus APB master signals between the FIFO arbiter and its surroundings.
// The master modport is the arbiter's view; the slave modport is the requesters/peripheral side.
interface fifo_apb_arbiter_if;
   logic        wr_req;
   logic [7:0]  wr_data;
   logic        wr_ack;
   logic        wr_fail;
   logic        rd_req;
   logic        rd_ack;
   logic        rd_fail;
   logic [7:0]  rd_data;
   logic        busy;
   logic [3:0]  PADDR;
   logic [31:0] PWDATA;
   logic        PWRITE;
   logic        PSEL;
   logic        PENABLE;
   logic [31:0] PRDATA;
   logic        PREADY;

   modport master (
      input  wr_req, wr_data, rd_req, PRDATA, PREADY,
      output wr_ack, wr_fail, rd_ack, rd_fail, rd_data, busy,
      output PADDR, PWDATA, PWRITE, PSEL, PENABLE
   );

   modport slave (
      output wr_req, wr_data, rd_req, PRDATA, PREADY,
      input  wr_ack, wr_fail, rd_ack, rd_fail, rd_data, busy,
      input  PADDR, PWDATA, PWRITE, PSEL, PENABLE
   );
endinterface

// File: rtl/fifo_apb_arbiter.sv
// APB master sharing a FIFO peripheral between one write and one read requester:
// each request is a status poll of FSR followed by the FIFO data transfer(s).
module fifo_apb_arbiter #(
   parameter int TIMEOUT = 16
) (
   input  logic               PCLK,
   input  logic               PRESET,
   fifo_apb_arbiter_if.master bus
);

   localparam int         CNT_W    = $clog2(TIMEOUT + 1);
   localparam logic [3:0] ADDR_FSR = 4'h0;
   localparam logic [3:0] ADDR_FWD = 4'h4;
   localparam logic [3:0] ADDR_FRD = 4'h8;

   typedef enum logic [3:0] {
      IDLE, ST_S, ST_A, WR_S, WR_A, TG_S, TG_A, DT_S, DT_A, DONE
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic             r_op_rd;
   logic             r_last_rd;
   logic [7:0]       r_wdata;
   logic [CNT_W-1:0] r_wait_cnt;

   logic             w_grant;
   logic             w_grant_rd;
   logic             w_in_access;
   logic             w_timeout;
   logic             w_fail_nxt;

   logic             r_psel;
   logic             r_penable;
   logic [3:0]       r_paddr;
   logic             r_pwrite;
   logic [31:0]      r_pwdata;
   logic             r_wr_ack;
   logic             r_wr_fail;
   logic             r_rd_ack;
   logic             r_rd_fail;
   logic [7:0]       r_rd_data;
   logic             r_busy;

   logic             w_psel;
   logic             w_penable;
   logic [3:0]       w_paddr;
   logic             w_pwrite;
   logic [31:0]      w_pwdata;
   logic             w_wr_ack;
   logic             w_wr_fail;
   logic             w_rd_ack;
   logic             w_rd_fail;
   logic [7:0]       w_rd_data;
   logic             w_busy;

   assign w_in_access = (r_state == ST_A) || (r_state == WR_A) ||
                        (r_state == TG_A) || (r_state == DT_A);
   // The TIMEOUT-th consecutive cycle without PREADY aborts the transfer.
   assign w_timeout   = w_in_access && !bus.PREADY &&
                        (r_wait_cnt == CNT_W'(TIMEOUT - 1));

   always_ff @(posedge PCLK or negedge PRESET) begin
      if (!PRESET) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_grant     = 1'b0;
      w_grant_rd  = 1'b0;
      w_fail_nxt  = 1'b0;
      case (r_state)
         IDLE: begin
            if (bus.wr_req && (!bus.rd_req || r_last_rd)) begin
               w_grant     = 1'b1;
               w_grant_rd  = 1'b0;
               w_state_nxt = ST_S;
            end else if (bus.rd_req) begin
               w_grant     = 1'b1;
               w_grant_rd  = 1'b1;
               w_state_nxt = ST_S;
            end
         end
         ST_S: w_state_nxt = ST_A;
         ST_A: begin
            if (bus.PREADY) begin
               if (!r_op_rd) begin
                  if (bus.PRDATA[1]) begin
                     w_state_nxt = DONE;
                     w_fail_nxt  = 1'b1;
                  end else begin
                     w_state_nxt = WR_S;
                  end
               end else if (bus.PRDATA[0]) begin
                  w_state_nxt = DONE;
                  w_fail_nxt  = 1'b1;
               end else begin
                  w_state_nxt = TG_S;
               end
            end else if (w_timeout) begin
               w_state_nxt = DONE;
               w_fail_nxt  = 1'b1;
            end
         end
         WR_S: w_state_nxt = WR_A;
         WR_A: begin
            if (bus.PREADY) begin
               w_state_nxt = DONE;
            end else if (w_timeout) begin
               w_state_nxt = DONE;
               w_fail_nxt  = 1'b1;
            end
         end
         TG_S: w_state_nxt = TG_A;
         TG_A: begin
            if (bus.PREADY) begin
               w_state_nxt = DT_S;
            end else if (w_timeout) begin
               w_state_nxt = DONE;
               w_fail_nxt  = 1'b1;
            end
         end
         DT_S: w_state_nxt = DT_A;
         DT_A: begin
            if (bus.PREADY) begin
               w_state_nxt = DONE;
            end else if (w_timeout) begin
               w_state_nxt = DONE;
               w_fail_nxt  = 1'b1;
            end
         end
         DONE:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // Outputs are decoded from the next state so the registered bus matches the state it enters.
   always_comb begin
      w_psel    = 1'b0;
      w_penable = 1'b0;
      w_paddr   = 4'h0;
      w_pwrite  = 1'b0;
      w_pwdata  = 32'h0;
      w_wr_ack  = 1'b0;
      w_wr_fail = 1'b0;
      w_rd_ack  = 1'b0;
      w_rd_fail = 1'b0;
      w_busy    = (w_state_nxt != IDLE);
      w_rd_data = r_rd_data;
      if ((r_state == DT_A) && bus.PREADY) begin
         w_rd_data = bus.PRDATA[7:0];
      end
      case (w_state_nxt)
         ST_S, ST_A: begin
            w_psel    = 1'b1;
            w_penable = (w_state_nxt == ST_A);
            w_paddr   = ADDR_FSR;
         end
         WR_S, WR_A: begin
            w_psel    = 1'b1;
            w_penable = (w_state_nxt == WR_A);
            w_paddr   = ADDR_FWD;
            w_pwrite  = 1'b1;
            w_pwdata  = {24'h0, r_wdata};
         end
         TG_S, TG_A: begin
            w_psel    = 1'b1;
            w_penable = (w_state_nxt == TG_A);
            w_paddr   = ADDR_FWD;
         end
         DT_S, DT_A: begin
            w_psel    = 1'b1;
            w_penable = (w_state_nxt == DT_A);
            w_paddr   = ADDR_FRD;
         end
         DONE: begin
            w_wr_ack  = !r_op_rd && !w_fail_nxt;
            w_wr_fail = !r_op_rd &&  w_fail_nxt;
            w_rd_ack  =  r_op_rd && !w_fail_nxt;
            w_rd_fail =  r_op_rd &&  w_fail_nxt;
         end
         default: ;
      endcase
   end

   // Write wins the first tie after reset, hence last grant starts as read.
   always_ff @(posedge PCLK or negedge PRESET) begin
      if (!PRESET) begin
         r_op_rd    <= 1'b0;
         r_last_rd  <= 1'b1;
         r_wait_cnt <= '0;
      end else begin
         if (w_grant) begin
            r_op_rd   <= w_grant_rd;
            r_last_rd <= w_grant_rd;
         end
         if (w_in_access && !bus.PREADY && !w_timeout) begin
            r_wait_cnt <= r_wait_cnt + CNT_W'(1);
         end else begin
            r_wait_cnt <= '0;
         end
      end
   end

   always_ff @(posedge PCLK) begin
      if (w_grant) begin
         r_wdata <= bus.wr_data;
      end
   end

   always_ff @(posedge PCLK or negedge PRESET) begin
      if (!PRESET) begin
         r_psel    <= 1'b0;
         r_penable <= 1'b0;
         r_paddr   <= 4'h0;
         r_pwrite  <= 1'b0;
         r_pwdata  <= 32'h0;
         r_wr_ack  <= 1'b0;
         r_wr_fail <= 1'b0;
         r_rd_ack  <= 1'b0;
         r_rd_fail <= 1'b0;
         r_rd_data <= 8'h0;
         r_busy    <= 1'b0;
      end else begin
         r_psel    <= w_psel;
         r_penable <= w_penable;
         r_paddr   <= w_paddr;
         r_pwrite  <= w_pwrite;
         r_pwdata  <= w_pwdata;
         r_wr_ack  <= w_wr_ack;
         r_wr_fail <= w_wr_fail;
         r_rd_ack  <= w_rd_ack;
         r_rd_fail <= w_rd_fail;
         r_rd_data <= w_rd_data;
         r_busy    <= w_busy;
      end
   end

   assign bus.PSEL    = r_psel;
   assign bus.PENABLE = r_penable;
   assign bus.PADDR   = r_paddr;
   assign bus.PWRITE  = r_pwrite;
   assign bus.PWDATA  = r_pwdata;
   assign bus.wr_ack  = r_wr_ack;
   assign bus.wr_fail = r_wr_fail;
   assign bus.rd_ack  = r_rd_ack;
   assign bus.rd_fail = r_rd_fail;
   assign bus.rd_data = r_rd_data;
   assign bus.busy    = r_busy;

endmodule

// File: tb/tb_fifo_apb_arbiter.sv
// Bench for fifo_apb_arbiter: behavioural APB FIFO peripheral, vector table of requests,
// and hand-written sequences for reset-during-transfer and round-robin ties.
module tb_fifo_apb_arbiter;

   localparam int TIMEOUT = 16;
   localparam int DEPTH   = 4;

   logic PCLK   = 1'b0;
   logic PRESET = 1'b1;

   fifo_apb_arbiter_if bus ();

   fifo_apb_arbiter #(.TIMEOUT(TIMEOUT)) dut (
      .PCLK   (PCLK),
      .PRESET (PRESET),
      .bus    (bus)
   );

   always #5 PCLK = ~PCLK;

   int n_pass = 0;
   int n_chk  = 0;
   int n_resp = 0;
   int pulse_cnt = 0;

   typedef struct {
      bit         rd;
      logic [7:0] wdata;
      int         wr_waits;
      int         rd_waits;
      bit         hang;
      int         kind;       // 0 = ack, 1 = fail
      logic [7:0] rdata;
      int         lat;
   } vec_t;

   typedef struct {
      bit         rd;
      int         kind;
      logic [7:0] rdata;
      int         lat;
   } exp_t;

   exp_t       sb_q[$];
   logic [12:0] apb_q[$];
   vec_t       vecs[13];

   // Peripheral knobs and state
   int         wr_waits = 0;
   int         rd_waits = 0;
   bit         hang     = 1'b0;
   logic [7:0] fifo_q[$];
   logic [7:0] hold = 8'h0;
   int         acc_cnt = 0;
   int         stab_err = 0;
   logic [3:0] s_addr = 4'h0;
   logic [31:0] s_wdata = 32'h0;
   logic       s_write = 1'b0;

   function automatic logic [12:0] px(input logic [3:0] a, input logic w, input logic [7:0] d);
      return {a, w, d};
   endfunction

   function automatic logic [3:0] codeof(input bit rd, input int kind);
      if (rd) return (kind == 0) ? 4'b0010 : 4'b0001;
      return (kind == 0) ? 4'b1000 : 4'b0100;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   // APB FIFO peripheral: responds on the falling edge so PREADY/PRDATA are stable at the rising edge.
   always @(negedge PCLK) begin
      int   waits;
      logic f, e;
      if (bus.PSEL === 1'b1 && bus.PENABLE === 1'b0) begin
         s_addr  = bus.PADDR;
         s_wdata = bus.PWDATA;
         s_write = bus.PWRITE;
         if (bus.PWRITE && bus.PWDATA[31:8] != 24'h0) stab_err++;
         acc_cnt    = 0;
         bus.PREADY = 1'b0;
         bus.PRDATA = 32'h0;
      end else if (bus.PSEL === 1'b1 && bus.PENABLE === 1'b1) begin
         if (bus.PADDR !== s_addr || bus.PWDATA !== s_wdata || bus.PWRITE !== s_write) stab_err++;
         waits = hang ? 1000000 : (s_write ? wr_waits : ((s_addr == 4'h4) ? rd_waits : 0));
         if (acc_cnt >= waits) begin
            bus.PREADY = 1'b1;
            if (s_write) begin
               if (s_addr == 4'h4 && fifo_q.size() < DEPTH) fifo_q.push_back(s_wdata[7:0]);
               apb_q.push_back(px(s_addr, 1'b1, s_wdata[7:0]));
               bus.PRDATA = 32'h0;
            end else begin
               case (s_addr)
                  4'h0: begin
                     f = (fifo_q.size() >= DEPTH);
                     e = (fifo_q.size() == 0);
                     bus.PRDATA = {30'h0, f, e};
                     apb_q.push_back(px(4'h0, 1'b0, 8'h0));
                  end
                  4'h4: begin
                     if (fifo_q.size() > 0) hold = fifo_q.pop_front();
                     bus.PRDATA = 32'h0000_00EE;
                     apb_q.push_back(px(4'h4, 1'b0, 8'h0));
                  end
                  4'h8: begin
                     bus.PRDATA = {24'hC3C3C3, hold};
                     apb_q.push_back(px(4'h8, 1'b0, hold));
                  end
                  default: begin
                     bus.PRDATA = 32'h0;
                     apb_q.push_back(px(s_addr, 1'b0, 8'h0));
                  end
               endcase
            end
         end else begin
            bus.PREADY = 1'b0;
         end
         acc_cnt++;
      end else begin
         bus.PREADY = 1'b0;
         bus.PRDATA = 32'h0;
         acc_cnt    = 0;
      end
   end

   always @(negedge PCLK) begin
      if ((bus.wr_ack | bus.wr_fail | bus.rd_ack | bus.rd_fail) === 1'b1) pulse_cnt++;
   end

   task automatic run_op(input vec_t v);
      int          lat;
      bit          got;
      bit          busy_ok;
      int          base;
      int          sbase;
      exp_t        e;
      logic [12:0] xq[$];
      wr_waits = v.wr_waits;
      rd_waits = v.rd_waits;
      hang     = v.hang;
      base     = apb_q.size();
      sbase    = stab_err;
      sb_q.push_back('{v.rd, v.kind, v.rdata, v.lat});
      if (!v.hang) xq.push_back(px(4'h0, 1'b0, 8'h0));
      if (!v.hang && v.kind == 0) begin
         if (v.rd) begin
            xq.push_back(px(4'h4, 1'b0, 8'h0));
            xq.push_back(px(4'h8, 1'b0, v.rdata));
         end else begin
            xq.push_back(px(4'h4, 1'b1, v.wdata));
         end
      end
      if (v.rd) bus.rd_req = 1'b1;
      else begin
         bus.wr_req  = 1'b1;
         bus.wr_data = v.wdata;
      end
      lat = 0; got = 1'b0; busy_ok = 1'b1;
      while (!got && lat < 64) begin
         @(negedge PCLK);
         lat++;
         if (bus.busy !== 1'b1) busy_ok = 1'b0;
         if ((bus.wr_ack | bus.wr_fail | bus.rd_ack | bus.rd_fail) === 1'b1) begin
            got = 1'b1;
            bus.wr_req = 1'b0;
            bus.rd_req = 1'b0;
         end
      end
      if (!got) begin
         check("resp_seen", 32'(got), 32'd1);
         bus.wr_req = 1'b0;
         bus.rd_req = 1'b0;
         void'(sb_q.pop_front());
      end else begin
         n_resp++;
         e = sb_q.pop_front();
         check("resp_code", {28'h0, bus.wr_ack, bus.wr_fail, bus.rd_ack, bus.rd_fail}, 32'(codeof(e.rd, e.kind)));
         check("latency", 32'(lat), 32'(e.lat));
         check("busy_during", 32'(busy_ok), 32'd1);
         check("psel_at_done", {30'h0, bus.PSEL, bus.PENABLE}, 32'h0);
         if (e.rd) check("rd_data", 32'(bus.rd_data), 32'(e.rdata));
         check("apb_count", 32'(apb_q.size() - base), 32'(xq.size()));
         if (apb_q.size() - base == xq.size())
            for (int i = 0; i < xq.size(); i++) check("apb_xfer", 32'(apb_q[base + i]), 32'(xq[i]));
         check("apb_stable", 32'(stab_err - sbase), 32'h0);
      end
      @(negedge PCLK);
      check("idle_gap", {30'h0, bus.busy, bus.PSEL}, 32'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int   n;
      int   cyc;
      int   pulses_before;
      bit   found;
      exp_t e;
      logic [3:0] code;

      vecs[0]  = '{1'b0, 8'hAA, 0, 0, 1'b0, 0, 8'h00, 5};
      vecs[1]  = '{1'b0, 8'hBB, 0, 0, 1'b0, 0, 8'h00, 5};
      vecs[2]  = '{1'b1, 8'h00, 0, 0, 1'b0, 0, 8'hAA, 7};
      vecs[3]  = '{1'b1, 8'h00, 0, 0, 1'b0, 0, 8'hBB, 7};
      vecs[4]  = '{1'b1, 8'h00, 0, 0, 1'b0, 1, 8'hBB, 3};
      vecs[5]  = '{1'b0, 8'h11, 3, 0, 1'b0, 0, 8'h00, 8};
      vecs[6]  = '{1'b0, 8'h22, 0, 0, 1'b0, 0, 8'h00, 5};
      vecs[7]  = '{1'b0, 8'h33, 0, 0, 1'b0, 0, 8'h00, 5};
      vecs[8]  = '{1'b0, 8'h44, 0, 0, 1'b0, 0, 8'h00, 5};
      vecs[9]  = '{1'b0, 8'h55, 0, 0, 1'b0, 1, 8'h00, 3};
      vecs[10] = '{1'b1, 8'h00, 0, 0, 1'b0, 0, 8'h11, 7};
      vecs[11] = '{1'b0, 8'h66, 0, 0, 1'b1, 1, 8'h00, 2 + TIMEOUT};
      vecs[12] = '{1'b1, 8'h00, 0, 2, 1'b0, 0, 8'h22, 9};

      bus.wr_req  = 1'b0;
      bus.rd_req  = 1'b0;
      bus.wr_data = 8'h0;

      #1 PRESET = 1'b0;
      @(negedge PCLK);
      @(negedge PCLK);
      check("reset_apb", {bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PADDR, bus.PWDATA[24:0]}, 32'h0);
      check("reset_ctl", {24'h0, bus.wr_ack, bus.wr_fail, bus.rd_ack, bus.rd_fail, bus.busy, 3'h0}, 32'h0);
      check("reset_rd_data", 32'(bus.rd_data), 32'h0);
      PRESET = 1'b1;
      @(negedge PCLK);
      check("post_reset_idle", {30'h0, bus.busy, bus.PSEL}, 32'h0);

      for (int i = 0; i < 13; i++) run_op(vecs[i]);

      // Reset while the pop trigger is waiting for PREADY
      rd_waits = 2;
      wr_waits = 0;
      hang     = 1'b0;
      bus.rd_req = 1'b1;
      found = 1'b0;
      cyc = 0;
      while (!found && cyc < 32) begin
         @(negedge PCLK);
         cyc++;
         if (bus.PSEL && bus.PENABLE && !bus.PWRITE && bus.PADDR == 4'h4) found = 1'b1;
      end
      check("reach_tg_a", 32'(found), 32'd1);
      pulses_before = pulse_cnt;
      #1 PRESET = 1'b0;
      bus.wr_req  = 1'b1;
      bus.wr_data = 8'h66;
      #1;
      check("rst_mid_drop", {29'h0, bus.PSEL, bus.PENABLE, bus.busy}, 32'h0);
      for (int i = 0; i < 3; i++) @(negedge PCLK);
      check("rst_mid_no_pulse", 32'(pulse_cnt - pulses_before), 32'h0);
      rd_waits = 0;
      PRESET = 1'b1;

      // Both requests held: grants must alternate starting with write
      sb_q.push_back('{1'b0, 0, 8'h00, 0});
      sb_q.push_back('{1'b1, 0, 8'h33, 0});
      sb_q.push_back('{1'b0, 0, 8'h00, 0});
      sb_q.push_back('{1'b1, 0, 8'h44, 0});
      n = 0;
      cyc = 0;
      while (n < 4 && cyc < 300) begin
         @(negedge PCLK);
         cyc++;
         code = {bus.wr_ack, bus.wr_fail, bus.rd_ack, bus.rd_fail};
         if (code != 4'b0) begin
            e = sb_q.pop_front();
            check("tie_grant", 32'(code), 32'(codeof(e.rd, e.kind)));
            if (e.rd) check("tie_rd_data", 32'(bus.rd_data), 32'(e.rdata));
            n++;
            n_resp++;
            if (n == 4) begin
               bus.wr_req = 1'b0;
               bus.rd_req = 1'b0;
            end
         end
      end
      check("tie_count", 32'(n), 32'd4);
      bus.wr_req = 1'b0;
      bus.rd_req = 1'b0;
      for (int i = 0; i < 4; i++) @(negedge PCLK);
      check("fifo_left", 32'(fifo_q.size()), 32'd2);
      check("pulse_total", 32'(pulse_cnt), 32'(n_resp));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/fifo_apb_arbiter.md
# fifo_apb_arbiter

APB master that shares the FIFO peripheral between one write requester and one read requester. Each request becomes a status poll (FSR) followed by the FIFO data transfers, so requesters never touch the APB bus directly. Sits between producer/consumer logic and the FIFO peripheral's APB slave port (FSR 0x0, FWD 0x4, FRD 0x8).

## Interface
- TIMEOUT, 16: max ACCESS cycles waiting for PREADY before abort (≥2).
- PCLK  in  1  clock, all logic rising-edge.
- PRESET  in  1  reset, asynchronous, active-low.
- wr_req  in  1  write request, level; held until wr_ack/wr_fail.
- wr_data  in  8  byte to push; captured on grant.
- wr_ack  out  1  one-cycle pulse: byte written to FIFO.
- wr_fail  out  1  one-cycle pulse: FIFO full or APB timeout, nothing written.
- rd_req  in  1  read request, level; held until rd_ack/rd_fail.
- rd_ack  out  1  one-cycle pulse: rd_data valid.
- rd_fail  out  1  one-cycle pulse: FIFO empty or APB timeout.
- rd_data  out  8  popped byte, valid with rd_ack, holds until next rd_ack.
- busy  out  1  high in every state except IDLE.
- PADDR  out  4,  PWDATA  out  32,  PWRITE  out  1,  PSEL  out  1,  PENABLE  out  1  APB master outputs.
- PRDATA  in  32,  PREADY  in  1  APB slave responses.

## Operation
- States: IDLE, ST_S, ST_A, WR_S, WR_A, TG_S, TG_A, DT_S, DT_A, DONE.
- IDLE: sample wr_req/rd_req. One active -> grant it. Both -> grant the one not in last_grant (round-robin); last_grant updates on every grant. Grant captures wr_data, sets op, goes ST_S.
- ST_S/ST_A: APB read addr 0x0. On completion FSR bit0=empty, bit1=full.
  - write op, full=1 -> DONE with fail; else -> WR_S.
  - read op, empty=1 -> DONE with fail; else -> TG_S.
- WR_S/WR_A: APB write addr 0x4, PWDATA = {24'h0, wr_data}. -> DONE ok.
- TG_S/TG_A: APB read addr 0x4 (pop trigger), PRDATA discarded. -> DT_S.
- DT_S/DT_A: APB read addr 0x8; rd_data <= PRDATA[7:0]. -> DONE ok.
- DONE: pulse exactly one of wr_ack/wr_fail/rd_ack/rd_fail per op; -> IDLE.
- Any *_A state: wait-counter increments each cycle PREADY=0; reaching TIMEOUT -> drop PSEL/PENABLE, DONE with fail. Counter clears on each SETUP.
- Requests deasserting mid-operation are ignored; operation completes.

## Timing
- All outputs registered. Reset (PRESET=0, async): state IDLE, last_grant=read (write wins first tie), all outputs 0, rd_data 0, counter 0.
- Reset mid-transfer: PSEL/PENABLE drop immediately, no ack/fail pulse, captured data lost.
- SETUP cycle: PSEL=1, PENABLE=0, PADDR/PWRITE/PWDATA valid. ACCESS: PSEL=1, PENABLE=1, same addr/data held until the edge where PREADY=1; PRDATA sampled on that edge.
- Back-to-back transfers: ACCESS -> next SETUP with PSEL staying 1, PENABLE dropping to 0.
- Outside transfers: PSEL=0, PENABLE=0, PADDR=0, PWRITE=0, PWDATA=0.
- Zero-wait latency, counted in cycles after the IDLE sampling edge: write ok -> wr_ack in cycle 5; read ok -> rd_ack in cycle 7; full/empty reject -> fail in cycle 3. Each PREADY wait cycle adds 1.
- Requester must deassert req by the rising edge ending the ack/fail cycle; a req still high when IDLE is next sampled is a new request.
- Minimum 1 IDLE cycle between operations.

## Test plan
- Reset, wr_req with wr_data=0xAA, zero-wait slave, FIFO empty -> APB read 0x0, APB write 0x4 PWDATA=0x000000AA, wr_ack in cycle 5, busy high cycles 1-5.
- After writes 0xAA, 0xBB: two rd_req ops -> each shows read 0x0, read 0x4, read 0x8; rd_ack with rd_data=0xAA then 0xBB in cycle 7.
- rd_req on empty FIFO (FSR=0x1) -> only read 0x0 issued, rd_fail in cycle 3, rd_data unchanged; wr_req on full FIFO (FSR=0x2) -> wr_fail, no write to 0x4.
- wr_req and rd_req both held high from reset, FIFO holding one byte -> grant order write, read, write, read; each grant alternates.
- Slave inserts 3 wait states on FWD write -> PADDR/PWDATA stable throughout ACCESS, wr_ack in cycle 8; PREADY held 0 for TIMEOUT=16 cycles -> PSEL drops, wr_fail pulses.
- PRESET asserted during TG_A -> PSEL/PENABLE/busy 0 immediately, no rd_ack/rd_fail; after release next tie grants write.
